// File: rtl/opora_if.sv
// opora_if: coefficient-load bus between the Ethernet receiver, the bank loader and the convolution cores.
//  Producer side (master drives): op_valid, op_sof, op_ch, op_data, swap_ok
//  Loader side (slave drives):    koef_en, koef_data, koef_addr, koef_bank,
//                                 bank_active, busy, load_done, err_short, err_long
interface opora_if #(
  parameter int W      = 16,
  parameter int N_BLK  = 4,
  parameter int MULT_N = 25,
  parameter int N_CH   = 2
);
  localparam int AW = MULT_N > 1 ? $clog2(MULT_N) : 1;
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic                    op_valid;
  logic                    op_sof;
  logic [CW-1:0]           op_ch;
  logic [W-1:0]            op_data;
  logic                    swap_ok;
  logic [N_BLK*N_CH-1:0]   koef_en;
  logic [W-1:0]            koef_data;
  logic [AW-1:0]           koef_addr;
  logic                    koef_bank;
  logic [N_CH-1:0]         bank_active;
  logic                    busy;
  logic                    load_done;
  logic                    err_short;
  logic                    err_long;
  modport slave (
    input  op_valid, op_sof, op_ch, op_data, swap_ok,
    output koef_en, koef_data, koef_addr, koef_bank, bank_active, busy, load_done, err_short, err_long
  );
  modport master (
    output op_valid, op_sof, op_ch, op_data, swap_ok,
    input  koef_en, koef_data, koef_addr, koef_bank, bank_active, busy, load_done, err_short, err_long
  );
endinterface

// File: rtl/opora_bank_loader.sv
// opora_bank_loader: writes opora frames into the shadow bank of per-channel double-buffered coefficient RAMs.
//  clke  clock (Ethernet domain)
//  rst   asynchronous active-high reset
//  bus   opora_if.slave: op_* word stream and swap_ok in; koef_* RAM write port,
//        bank_active, busy and the load_done/err_short/err_long pulses out
module opora_bank_loader #(
  parameter int W      = 16,
  parameter int N_BLK  = 4,
  parameter int MULT_N = 25,
  parameter int N_CH   = 2
) (
  input logic    clke,
  input logic    rst,
  opora_if.slave bus
);
  localparam int NUM_TAPS = N_BLK * MULT_N;
  localparam int AW = MULT_N > 1 ? $clog2(MULT_N) : 1;
  localparam int BW = N_BLK > 1 ? $clog2(N_BLK) : 1;
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int NE = N_BLK * N_CH;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DISCARD} state_t;
  state_t          r_state, w_state_n;
  logic [AW-1:0]   r_addr, w_addr;
  logic [BW-1:0]   r_blk, w_blk;
  logic [CW-1:0]   r_ch, w_ch;
  logic            r_over;
  logic [NE-1:0]   r_koef_en;
  logic [W-1:0]    r_koef_data;
  logic [AW-1:0]   r_koef_addr;
  logic            r_koef_bank;
  logic [N_CH-1:0] r_bank_active;
  logic            r_load_done, r_err_short, r_err_long;
  logic            w_good, w_start, w_bad, w_word, w_wr, w_last, w_commit, w_err_s, w_err_l;
  // A good sof starts a new frame from any state; the word itself is tap 0.
  // r_over remembers that a COMMIT-state frame already overran, so the
  // trailing words raise err_long only once and the tail is discarded.
  always_comb begin
    w_good    = 32'(bus.op_ch) < N_CH;
    w_start   = bus.op_valid & bus.op_sof & w_good;
    w_bad     = bus.op_valid & bus.op_sof & ~w_good;
    w_word    = bus.op_valid & ~bus.op_sof;
    w_wr      = w_start | (r_state == LOAD & w_word);
    w_addr    = w_start ? '0 : r_addr;
    w_blk     = w_start ? '0 : r_blk;
    w_ch      = w_start ? bus.op_ch : r_ch;
    w_last    = int'(w_blk) * MULT_N + int'(w_addr) == NUM_TAPS - 1;
    w_commit  = r_state == COMMIT & ~(bus.op_valid & bus.op_sof) & bus.swap_ok;
    w_err_s   = w_start & (r_state == LOAD | r_state == COMMIT);
    w_err_l   = w_bad | (w_word & (r_state == IDLE | (r_state == COMMIT & ~r_over)));
    w_state_n = w_bad ? DISCARD :
                w_start ? LOAD :
                (r_state == LOAD && w_word && w_last) ? COMMIT :
                w_commit ? ((r_over | w_word) ? DISCARD : IDLE) :
                r_state;
  end
  always_ff @(posedge clke or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_blk         <= '0;
      r_ch          <= '0;
      r_over        <= 1'b0;
      r_koef_en     <= '0;
      r_koef_data   <= '0;
      r_koef_addr   <= '0;
      r_koef_bank   <= 1'b0;
      r_bank_active <= '0;
      r_load_done   <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_koef_en   <= w_wr ? NE'(1) << (int'(w_ch) * N_BLK + int'(w_blk)) : '0;
      if (w_wr) begin
        r_koef_data <= bus.op_data;
        r_koef_addr <= w_addr;
        r_koef_bank <= ~r_bank_active[w_ch];
        r_ch        <= w_ch;
        r_addr      <= w_addr == AW'(MULT_N - 1) ? '0 : w_addr + 1'b1;
        r_blk       <= w_addr == AW'(MULT_N - 1) ? w_blk + 1'b1 : w_blk;
      end
      r_over        <= w_start ? 1'b0 : r_over | (r_state == COMMIT & w_word);
      r_bank_active <= w_commit ? r_bank_active ^ (N_CH'(1) << r_ch) : r_bank_active;
      r_load_done   <= w_commit;
      r_err_short   <= w_err_s;
      r_err_long    <= w_err_l;
    end
  end
  assign bus.koef_en     = r_koef_en;
  assign bus.koef_data   = r_koef_data;
  assign bus.koef_addr   = r_koef_addr;
  assign bus.koef_bank   = r_koef_bank;
  assign bus.bank_active = r_bank_active;
  assign bus.busy        = r_state != IDLE;
  assign bus.load_done   = r_load_done;
  assign bus.err_short   = r_err_short;
  assign bus.err_long    = r_err_long;
endmodule

// File: tb/tb_opora_bank_loader.sv
// tb_opora_bank_loader: directed frames with a write scoreboard and pulse counters.
// Three channels are used so that channel code 3 is representable and invalid.
module tb_opora_bank_loader;
  localparam int W = 16, NB = 4, MN = 25, NC = 3;
  logic clke = 1'b0;
  logic rst  = 1'b1;
  always #5 clke = ~clke;
  opora_if #(.W(W), .N_BLK(NB), .MULT_N(MN), .N_CH(NC)) bus ();
  opora_bank_loader #(.W(W), .N_BLK(NB), .MULT_N(MN), .N_CH(NC)) dut (.clke(clke), .rst(rst), .bus(bus));
  int n_cmp = 0, n_err = 0, cyc = 0;
  int n_wr = 0, n_done = 0, n_es = 0, n_el = 0, last_wr = 0, done_cyc = 0;
  logic [63:0] q[$];
  logic [NC-1:0] ba = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] exp_wr(input int c, input int k, input logic [15:0] d);
    logic [NB*NC-1:0] en;
    en = '0;
    en[c*NB + k/MN] = 1'b1;
    return {30'd0, en, 5'(k % MN), d, ~ba[c]};
  endfunction
  always @(posedge clke) cyc <= cyc + 1;
  always @(negedge clke) begin
    if (bus.koef_en != '0) begin
      if (q.size() == 0) chk("unexpected_write", 64'(bus.koef_en), 64'd0);
      else chk("write", {30'd0, bus.koef_en, bus.koef_addr, bus.koef_data, bus.koef_bank}, q.pop_front());
      n_wr++;
      last_wr = cyc;
    end
    if (bus.load_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.err_short) n_es++;
    if (bus.err_long) n_el++;
    if (bus.err_short | bus.err_long) chk("one_err", 64'(bus.err_short & bus.err_long), 64'd0);
  end
  task automatic word(input logic sof, input logic [1:0] ch, input logic [15:0] d);
    bus.op_valid = 1'b1;
    bus.op_sof   = sof;
    bus.op_ch    = ch;
    bus.op_data  = d;
    @(posedge clke); #1;
    bus.op_valid = 1'b0;
    bus.op_sof   = 1'b0;
  endtask
  task automatic frame(input int c, input int n, input int n_exp);
    for (int k = 0; k < n; k++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (k < n_exp) q.push_back(exp_wr(c, k, d));
      word(k == 0, 2'(c), d);
    end
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge clke);
    #1;
  endtask
  initial begin
    int w0, d0, es0, el0;
    bus.op_valid = 1'b0;
    bus.op_sof   = 1'b0;
    bus.op_ch    = '0;
    bus.op_data  = '0;
    bus.swap_ok  = 1'b0;
    settle(3);
    chk("rst_en", 64'(bus.koef_en), 64'd0);
    chk("rst_bank_active", 64'(bus.bank_active), 64'd0);
    chk("rst_flags", 64'({bus.busy, bus.load_done, bus.err_short, bus.err_long, bus.koef_bank}), 64'd0);
    rst = 1'b0;
    settle(1);
    // 1: full ch0 frame with swap allowed
    bus.swap_ok = 1'b1;
    w0 = n_wr; d0 = n_done; es0 = n_es; el0 = n_el;
    frame(0, 100, 100);
    settle(3);
    ba[0] = 1'b1;
    chk("t1_writes", 64'(n_wr - w0), 64'd100);
    chk("t1_done", 64'(n_done - d0), 64'd1);
    chk("t1_done_latency", 64'(done_cyc - last_wr), 64'd1);
    chk("t1_bank_active", 64'(bus.bank_active), 64'(ba));
    chk("t1_busy", 64'(bus.busy), 64'd0);
    chk("t1_errs", 64'(n_es - es0 + n_el - el0), 64'd0);
    // 2: short ch1 frame interrupted by a new full ch1 frame
    w0 = n_wr; d0 = n_done; es0 = n_es; el0 = n_el;
    frame(1, 60, 60);
    frame(1, 100, 100);
    settle(3);
    ba[1] = 1'b1;
    chk("t2_err_short", 64'(n_es - es0), 64'd1);
    chk("t2_done", 64'(n_done - d0), 64'd1);
    chk("t2_bank_active", 64'(bus.bank_active), 64'(ba));
    chk("t2_writes", 64'(n_wr - w0), 64'd160);
    // 3: ch0 frame of 105 words
    w0 = n_wr; d0 = n_done; es0 = n_es; el0 = n_el;
    frame(0, 105, 100);
    settle(3);
    ba[0] = 1'b0;
    chk("t3_err_long", 64'(n_el - el0), 64'd1);
    chk("t3_err_short", 64'(n_es - es0), 64'd0);
    chk("t3_writes", 64'(n_wr - w0), 64'd100);
    chk("t3_done", 64'(n_done - d0), 64'd1);
    chk("t3_bank_active", 64'(bus.bank_active), 64'(ba));
    // 4: swap held off for 200 cycles
    bus.swap_ok = 1'b0;
    w0 = n_wr; d0 = n_done;
    frame(0, 100, 100);
    settle(200);
    chk("t4_busy_wait", 64'(bus.busy), 64'd1);
    chk("t4_no_done", 64'(n_done - d0), 64'd0);
    chk("t4_bank_hold", 64'(bus.bank_active), 64'(ba));
    bus.swap_ok = 1'b1;
    settle(3);
    ba[0] = 1'b1;
    chk("t4_done", 64'(n_done - d0), 64'd1);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    chk("t4_bank_active", 64'(bus.bank_active), 64'(ba));
    // 5: invalid channel code
    w0 = n_wr; d0 = n_done; es0 = n_es; el0 = n_el;
    frame(3, 100, 0);
    settle(3);
    chk("t5_err_long", 64'(n_el - el0), 64'd1);
    chk("t5_writes", 64'(n_wr - w0), 64'd0);
    chk("t5_done", 64'(n_done - d0), 64'd0);
    chk("t5_bank_active", 64'(bus.bank_active), 64'(ba));
    // 6: reset in the middle of a frame
    w0 = n_wr; d0 = n_done;
    frame(1, 40, 40);
    settle(1);
    rst = 1'b1;
    #1;
    chk("t6_rst_en", 64'(bus.koef_en), 64'd0);
    chk("t6_rst_bank_active", 64'(bus.bank_active), 64'd0);
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    chk("t6_rst_data", 64'({bus.koef_data, bus.koef_addr}), 64'd0);
    ba = '0;
    settle(2);
    rst = 1'b0;
    settle(1);
    frame(0, 100, 100);
    settle(3);
    ba[0] = 1'b1;
    chk("t6_writes", 64'(n_wr - w0), 64'd140);
    chk("t6_done", 64'(n_done - d0), 64'd1);
    chk("t6_bank_active", 64'(bus.bank_active), 64'(ba));
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
